// File: rtl/ifq_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// The entry layout is fixed at 32-bit fields; if_id_queue's XLEN must stay 32.
package ifq_pkg;

  localparam int IFQ_XLEN  = 32;
  localparam int IFQ_DEPTH = 4;
  localparam int PTR_W     = $clog2(IFQ_DEPTH);

  // addi x0,x0,0
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } ifq_entry_t;

  // What decode sees when the queue has nothing to offer.
  function automatic ifq_entry_t nop_entry();
    ifq_entry_t e;
    e.ins  = NOP_INS;
    e.pc   = '0;
    e.pcp4 = '0;
    return e;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Entry array for if_id_queue: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner's count.
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = PTR_W
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  ifq_entry_t      wdata,
  input  logic [AW-1:0]   raddr,
  output ifq_entry_t      rdata
);

  ifq_entry_t mem_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (we && (waddr == AW'(gi))) begin
          mem_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with flush; decode sees a NOP when empty.
// Optional macro IFQ_BYPASS_EN: fall-through from in_* to out_* when the queue is empty.
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int XLEN  = IFQ_XLEN,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_ins,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_pcp4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_ins,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pcp4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       has_data;
  logic       bypass;
  logic       push;
  logic       pop;
  logic       store;
  logic       deq;
  logic       we;
  ifq_entry_t wdata;
  ifq_entry_t rdata;
  ifq_entry_t head;

  assign has_data = (count_q != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = !has_data && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = (count_q != FULL);
  assign out_valid = has_data || bypass;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A bypassed triple taken by decode in the same cycle never touches storage.
  assign store     = push && !(bypass && out_ready);
  assign deq       = pop && has_data;

  assign wdata.ins  = in_ins;
  assign wdata.pc   = in_pc;
  assign wdata.pcp4 = in_pcp4;

  ifq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    head = nop_entry();
    if (has_data) begin
      head = rdata;
    end else if (bypass) begin
      head = wdata;
    end
  end

  assign out_ins  = head.ins;
  assign out_pc   = head.pc;
  assign out_pcp4 = head.pcp4;
  assign count    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    // Flush drops everything, including a push or pop offered this cycle.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      we = store;
      if (store) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(store) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed stimulus pushes expectations, a negedge monitor pops and compares.
// Build with +define+IFQ_BYPASS_EN to exercise the fall-through variant.
module tb_if_id_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } exp_t;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ins, in_pc, in_pcp4, out_ins, out_pc, out_pcp4;
  logic [2:0]  count;

  exp_t exp_q[$];
  int   sz_snap  = 0;
  bit   byp_used = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  if_id_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ins    (in_ins),
    .in_pc     (in_pc),
    .in_pcp4   (in_pcp4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .out_pcp4  (out_pcp4),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected triples enter the scoreboard when the queue can take them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else if (in_valid && sz_snap != 4 && !byp_used) begin
      exp_q.push_back('{in_ins, in_pc, in_pcp4});
    end
  end

  // Monitor: compare status and head every cycle; pop on a consumed head.
  always @(negedge clk) begin
    int   sz;
    bit   ev;
    exp_t e;
    sz       = exp_q.size();
    sz_snap  = sz;
    byp_used = 1'b0;
    ev = (sz != 0) || (BYP && in_valid && !flush && !rst);
    check("out_valid", {31'b0, out_valid}, {31'b0, ev});
    check("count", {29'b0, count}, 32'(sz));
    check("in_ready", {31'b0, in_ready}, {31'b0, (sz != 4)});
    if (ev) begin
      if (sz != 0) e = exp_q[0];
      else e = '{in_ins, in_pc, in_pcp4};
      check("out_ins", out_ins, e.ins);
      check("out_pc", out_pc, e.pc);
      check("out_pcp4", out_pcp4, e.pcp4);
      if (out_ready && !flush && !rst) begin
        $display("pop ins=%h pc=%h pcp4=%h%s", out_ins, out_pc, out_pcp4, (sz == 0) ? " (bypass)" : "");
        if (sz != 0) void'(exp_q.pop_front());
        else byp_used = 1'b1;
      end
    end else begin
      check("empty_ins", out_ins, NOP);
      check("empty_pc", out_pc, 32'h0);
      check("empty_pcp4", out_pcp4, 32'h0);
    end
  end

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_ins    = ins;
    in_pc     = pc;
    in_pcp4   = pc + 32'd4;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = '0; in_pc = '0; in_pcp4 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset mid-run with three entries held
    drive(1'b1, 32'h0010_0093, 32'h100, 1'b0, 1'b0);
    drive(1'b1, 32'h0020_0113, 32'h104, 1'b0, 1'b0);
    drive(1'b1, 32'h0030_0193, 32'h108, 1'b0, 1'b0);
    check("t1_count3", {29'b0, count}, 32'd3);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t1_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t1_rst_count", {29'b0, count}, 32'd0);
    check("t1_rst_ready", {31'b0, in_ready}, 32'd1);
    check("t1_rst_ins", out_ins, NOP);
    @(posedge clk);
    #1 rst = 1'b0;

    // 2: fill to DEPTH, then a fifth offer is held off
    drive(1'b1, 32'h0050_0093, 32'h200, 1'b0, 1'b0);
    drive(1'b1, 32'h00a0_0113, 32'h204, 1'b0, 1'b0);
    drive(1'b1, 32'h0020_81b3, 32'h208, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0013, 32'h20c, 1'b0, 1'b0);
    check("t2_full_count", {29'b0, count}, 32'd4);
    check("t2_full_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 32'h0070_0213, 32'h210, 1'b0, 1'b0);
    drive(1'b1, 32'h0070_0213, 32'h210, 1'b0, 1'b0);
    check("t2_ignored_count", {29'b0, count}, 32'd4);

    // 3: drain with interleaved pushes across the pointer wrap
    drive(1'b1, 32'h0070_0213, 32'h210, 1'b1, 1'b0);
    check("t3_after_pop_count", {29'b0, count}, 32'd3);
    drive(1'b1, 32'h0070_0213, 32'h210, 1'b1, 1'b0);
    drive(1'b1, 32'h0080_0293, 32'h214, 1'b1, 1'b0);
    drive(1'b1, 32'h0090_0313, 32'h218, 1'b1, 1'b0);
    drive(1'b1, 32'h00a0_0393, 32'h21c, 1'b1, 1'b0);
    check("t3_steady_count", {29'b0, count}, 32'd3);
    idle(5);
    check("t3_drained", {29'b0, count}, 32'd0);

    // 4: simultaneous push and pop at count=2
    drive(1'b1, 32'h0010_0413, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h0020_0493, 32'h304, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'h0100_0513 + 32'(i), 32'h308 + 32'(4 * i), 1'b1, 1'b0);
    check("t4_count2", {29'b0, count}, 32'd2);
    idle(3);

    // 5: flush with a push and pop offered in the same cycle
    drive(1'b1, 32'h0110_0593, 32'h400, 1'b0, 1'b0);
    drive(1'b1, 32'h0120_0613, 32'h404, 1'b0, 1'b0);
    drive(1'b1, 32'h0130_0693, 32'h408, 1'b0, 1'b0);
    check("t5_count3", {29'b0, count}, 32'd3);
    drive(1'b1, 32'h0140_0713, 32'h40c, 1'b1, 1'b1);
    check("t5_flush_count", {29'b0, count}, 32'd0);
    check("t5_flush_valid", {31'b0, out_valid && !in_valid}, 32'd0);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("t5_flush_valid_idle", {31'b0, out_valid}, 32'd0);
    check("t5_flush_ins", out_ins, NOP);
    idle(2);

    // 6: empty queue, offer with decode ready
    in_valid = 1'b1; in_ins = 32'h0010_0093; in_pc = 32'h500; in_pcp4 = 32'h504;
    out_ready = 1'b1; flush = 1'b0;
    #1;
    check("t6_same_cycle_valid", {31'b0, out_valid}, {31'b0, BYP});
    check("t6_same_cycle_ins", out_ins, BYP ? 32'h0010_0093 : NOP);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    check("t6_after_count", {29'b0, count}, BYP ? 32'd0 : 32'd1);
    check("t6_after_valid", {31'b0, out_valid}, BYP ? 32'd0 : 32'd1);
    idle(3);
    check("t6_final_count", {29'b0, count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
